// File: rtl/serial_rx_if.sv
// Parallel-side and line-side signals of the serial receiver, bundled so the
// receiver and its consumer connect through one port.
interface serial_rx_if #(
    parameter int DATA_BITS = 8
) ();
    logic                 in;
    logic                 ack;
    logic [DATA_BITS-1:0] data_out;
    logic                 valid;
    logic                 frame_err;
    logic                 overrun;
    logic                 busy;

    modport master (
        output in,
        output ack,
        input  data_out,
        input  valid,
        input  frame_err,
        input  overrun,
        input  busy
    );

    modport slave (
        input  in,
        input  ack,
        output data_out,
        output valid,
        output frame_err,
        output overrun,
        output busy
    );
endinterface

// File: rtl/serial_rx.sv
// Serial receiver: deframes start / MSB-first data / stop symbols sampled one
// bit per clk1 cycle into a parallel byte with a valid/ack handshake, and
// reports framing errors (pulse) and overruns (sticky).
module serial_rx #(
    parameter int DATA_BITS    = 8,
    parameter int START_CYCLES = 2,
    parameter int STOP_CYCLES  = 2
) (
    input  logic       clk1,
    input  logic       rst,
    serial_rx_if.slave bus
);
    // One shared counter serves the start, data and stop phases.
    localparam int MAX_SD  = (START_CYCLES > DATA_BITS) ? START_CYCLES : DATA_BITS;
    localparam int MAX_CNT = (STOP_CYCLES > MAX_SD) ? STOP_CYCLES : MAX_SD;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_CYCLES - 1);
    localparam logic [CNT_W-1:0] DATA_LAST  = CNT_W'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0] STOP_LAST  = CNT_W'(STOP_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_e;

    // Synchronizer: line idles high, so both stages reset to 1.
    logic sync1_q;
    logic sync2_q;

    state_e               state_q,     state_d;
    logic [CNT_W-1:0]     cnt_q,       cnt_d;
    logic [DATA_BITS-1:0] shift_q,     shift_d;
    logic                 bad_q,       bad_d;
    logic                 armed_q,     armed_d;
    logic [DATA_BITS-1:0] data_out_q,  data_out_d;
    logic                 valid_q,     valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q,   overrun_d;
    logic                 busy_q,      busy_d;

    logic s;
    logic deliver;
    logic bad_now;
    logic ack_eff;

    assign s       = sync2_q;
    assign ack_eff = bus.ack & valid_q;

    // Two-stage synchronizer on the asynchronous serial line.
    always_ff @(posedge clk1) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= bus.in;
            sync2_q <= sync1_q;
        end
    end

    // Frame FSM next-state, shift/count update and handshake bookkeeping.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        bad_d       = bad_q;
        armed_d     = armed_q;
        data_out_d  = data_out_q;
        valid_d     = valid_q;
        frame_err_d = 1'b0;
        overrun_d   = overrun_q;
        deliver     = 1'b0;
        bad_now     = bad_q | ~s;

        case (state_q)
            ST_IDLE: begin
                if (s) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    // First low sample of the start symbol.
                    if (START_CYCLES == 1) begin
                        state_d = ST_DATA;
                        cnt_d   = CNT_ZERO;
                    end else begin
                        state_d = ST_START;
                        cnt_d   = CNT_ONE;
                    end
                end else begin
                    // Low line while disarmed: wait for a high sample first.
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (!s) begin
                    if (cnt_q == START_LAST) begin
                        state_d = ST_DATA;
                        cnt_d   = CNT_ZERO;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else begin
                    // Start symbol too short: treat as a glitch, silently.
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                    armed_d = 1'b1;
                end
            end
            ST_DATA: begin
                // MSB first: shifting left leaves the first sample on top.
                shift_d    = shift_q << 1;
                shift_d[0] = s;
                if (cnt_q == DATA_LAST) begin
                    state_d = ST_STOP;
                    cnt_d   = CNT_ZERO;
                    bad_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_STOP: begin
                if (cnt_q == STOP_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                    bad_d   = 1'b0;
                    if (!bad_now) begin
                        deliver = 1'b1;
                        armed_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                        armed_d     = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                    bad_d = bad_now;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
                bad_d   = 1'b0;
                armed_d = 1'b0;
            end
        endcase

        if (deliver) begin
            data_out_d = shift_q;
            valid_d    = 1'b1;
            if (valid_q && !bus.ack) begin
                overrun_d = 1'b1;
            end else if (ack_eff) begin
                overrun_d = 1'b0;
            end else begin
                overrun_d = overrun_q;
            end
        end else if (ack_eff) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State, datapath and registered output flops.
    always_ff @(posedge clk1) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= CNT_ZERO;
            shift_q     <= '0;
            bad_q       <= 1'b0;
            armed_q     <= 1'b0;
            data_out_q  <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            bad_q       <= bad_d;
            armed_q     <= armed_d;
            data_out_q  <= data_out_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.data_out  = data_out_q;
    assign bus.valid     = valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.overrun   = overrun_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_serial_rx.sv
// Directed bench for serial_rx: default 8/2/2 instance plus a 5/1/1 instance.
// Inputs change on falling edges; outputs are checked on falling edges.
module tb_serial_rx;
    logic clk1;
    logic rst;
    int   checks;
    int   errors;

    serial_rx_if #(.DATA_BITS(8)) ia ();
    serial_rx_if #(.DATA_BITS(5)) ib ();

    serial_rx #(.DATA_BITS(8), .START_CYCLES(2), .STOP_CYCLES(2)) dut_a (
        .clk1 (clk1),
        .rst  (rst),
        .bus  (ia)
    );

    serial_rx #(.DATA_BITS(5), .START_CYCLES(1), .STOP_CYCLES(1)) dut_b (
        .clk1 (clk1),
        .rst  (rst),
        .bus  (ib)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk1);
    endtask

    // Drive n bits MSB first, one per cycle, then return the line high.
    task automatic send_bits(input logic [31:0] bits, input int n, input bit sel_b);
        for (int i = n - 1; i >= 0; i--) begin
            if (sel_b) ib.in = bits[i];
            else       ia.in = bits[i];
            @(negedge clk1);
        end
        if (sel_b) ib.in = 1'b1;
        else       ia.in = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        ia.in  = 1'b1;
        ia.ack = 1'b0;
        ib.in  = 1'b1;
        ib.ack = 1'b0;
        rst    = 1'b1;
        step(2);
        chk("rst_data",  32'(ia.data_out),  32'h0);
        chk("rst_valid", 32'(ia.valid),     32'h0);
        chk("rst_ferr",  32'(ia.frame_err), 32'h0);
        chk("rst_ovr",   32'(ia.overrun),   32'h0);
        chk("rst_busy",  32'(ia.busy),      32'h0);
        rst = 1'b0;
        step(3);

        // Good frame 0xA5: last bit sampled at E0+11.
        send_bits({2'b00, 8'hA5, 2'b11, 20'h0} >> 20, 12, 1'b0);
        step(1);
        chk("a5_valid_e12", 32'(ia.valid), 32'h0);
        chk("a5_busy_e12",  32'(ia.busy),  32'h1);
        step(1);
        chk("a5_valid", 32'(ia.valid),     32'h1);
        chk("a5_data",  32'(ia.data_out),  32'hA5);
        chk("a5_ferr",  32'(ia.frame_err), 32'h0);
        chk("a5_ovr",   32'(ia.overrun),   32'h0);
        chk("a5_busy",  32'(ia.busy),      32'h0);
        step(2);
        chk("a5_hold", 32'(ia.valid), 32'h1);
        ia.ack = 1'b1;
        step(1);
        ia.ack = 1'b0;
        chk("a5_acked", 32'(ia.valid), 32'h0);

        // Glitch: one low cycle; busy high only after E0+2.
        ia.in = 1'b0;
        step(1);
        ia.in = 1'b1;
        step(1);
        chk("gl_busy_e1", 32'(ia.busy), 32'h0);
        step(1);
        chk("gl_busy_e2", 32'(ia.busy), 32'h1);
        step(1);
        chk("gl_busy_e3", 32'(ia.busy),      32'h0);
        chk("gl_valid",   32'(ia.valid),     32'h0);
        chk("gl_ferr",    32'(ia.frame_err), 32'h0);
        step(2);
        send_bits(32'({2'b00, 8'h3C, 2'b11}), 12, 1'b0);
        step(2);
        chk("3c_valid", 32'(ia.valid),    32'h1);
        chk("3c_data",  32'(ia.data_out), 32'h3C);
        ia.ack = 1'b1;
        step(1);
        ia.ack = 1'b0;

        // Framing error: 0xFF with the second stop bit low.
        send_bits(32'({2'b00, 8'hFF, 2'b10}), 12, 1'b0);
        step(1);
        chk("fe_ferr_e12", 32'(ia.frame_err), 32'h0);
        step(1);
        chk("fe_ferr_e13", 32'(ia.frame_err), 32'h1);
        chk("fe_valid",    32'(ia.valid),     32'h0);
        chk("fe_data",     32'(ia.data_out),  32'h3C);
        step(1);
        chk("fe_ferr_e14", 32'(ia.frame_err), 32'h0);
        step(2);
        send_bits(32'({2'b00, 8'h81, 2'b11}), 12, 1'b0);
        step(2);
        chk("81_valid", 32'(ia.valid),    32'h1);
        chk("81_data",  32'(ia.data_out), 32'h81);
        ia.ack = 1'b1;
        step(1);
        ia.ack = 1'b0;
        step(2);

        // Back-to-back 0x12, 0x34 without ack: overrun.
        send_bits(32'({2'b00, 8'h12, 2'b11, 2'b00, 8'h34, 2'b11}), 24, 1'b0);
        step(2);
        chk("b2b_valid", 32'(ia.valid),    32'h1);
        chk("b2b_data",  32'(ia.data_out), 32'h34);
        chk("b2b_ovr",   32'(ia.overrun),  32'h1);
        ia.ack = 1'b1;
        step(1);
        ia.ack = 1'b0;
        chk("b2b_ack_valid", 32'(ia.valid),   32'h0);
        chk("b2b_ack_ovr",   32'(ia.overrun), 32'h0);
        step(2);

        // Same again with ack asserted on the edge that delivers 0x34.
        send_bits(32'({2'b00, 8'h12, 2'b11, 2'b00, 8'h34, 2'b11}), 24, 1'b0);
        step(1);
        chk("b2b2_mid_data", 32'(ia.data_out), 32'h12);
        ia.ack = 1'b1;
        step(1);
        ia.ack = 1'b0;
        chk("b2b2_valid", 32'(ia.valid),    32'h1);
        chk("b2b2_data",  32'(ia.data_out), 32'h34);
        chk("b2b2_ovr",   32'(ia.overrun),  32'h0);
        ia.ack = 1'b1;
        step(1);
        ia.ack = 1'b0;
        chk("b2b2_acked", 32'(ia.valid), 32'h0);
        step(2);

        // Reset during data bit 4 of a frame.
        send_bits(32'({2'b00, 4'b1111}), 6, 1'b0);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("mr_data",  32'(ia.data_out),  32'h0);
        chk("mr_valid", 32'(ia.valid),     32'h0);
        chk("mr_ferr",  32'(ia.frame_err), 32'h0);
        chk("mr_ovr",   32'(ia.overrun),   32'h0);
        chk("mr_busy",  32'(ia.busy),      32'h0);
        step(12);
        chk("mr_no_valid", 32'(ia.valid), 32'h0);
        send_bits(32'({2'b00, 8'h5A, 2'b11}), 12, 1'b0);
        step(2);
        chk("5a_valid", 32'(ia.valid),    32'h1);
        chk("5a_data",  32'(ia.data_out), 32'h5A);

        // 5/1/1 instance: frame 0b10110, delivered after E0+8.
        send_bits(32'({1'b0, 5'b10110, 1'b1}), 7, 1'b1);
        step(1);
        chk("p5_valid_e7", 32'(ib.valid), 32'h0);
        step(1);
        chk("p5_valid", 32'(ib.valid),    32'h1);
        chk("p5_data",  32'(ib.data_out), 32'h16);
        chk("p5_ferr",  32'(ib.frame_err), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
